// File: rtl/sprite_rom_arbiter_if.sv
// Renderer/ROM bus of the sprite ROM arbiter: row requests, acks and the shared ROM port.
// master = renderers plus ROM side, slave = arbiter.
interface sprite_rom_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 4,
    parameter int DW   = 8
);
    logic [NREQ-1:0]         req;
    logic [NREQ-1:0][AW-1:0] addr;
    logic [NREQ-1:0]         ack;
    logic [DW-1:0]           data;
    logic [AW-1:0]           rom_addr;
    logic [DW-1:0]           rom_bits;

    modport master (output req, addr, rom_bits, input ack, data, rom_addr);
    modport slave  (input req, addr, rom_bits, output ack, data, rom_addr);
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one combinational sprite ROM between NREQ renderers,
// two-stage fetch pipeline (address register, data register) plus sticky miss flags.

module sprite_rom_arbiter_lane (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic in_s1,
    input  logic acked,
    input  logic win_fall,
    input  logic frame_start,
    output logic eligible,
    output logic miss
);
    // A lane with its fetch in flight or being acked must not be granted again.
    assign eligible = req & ~in_s1 & ~acked;

    // Set beats clear when the window closes on the frame_start cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                    miss <= 1'b0;
        else if (win_fall && eligible) miss <= 1'b1;
        else if (frame_start)          miss <= 1'b0;
    end
endmodule

module sprite_rom_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 4,
    parameter int DW   = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                window,
    input  logic                frame_start,
    sprite_rom_arbiter_if.slave bus,
    output logic                busy,
    output logic [NREQ-1:0]     miss
);
    localparam int IDW    = $clog2(NREQ);
    localparam int STAGES = 1;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [AW-1:0]  addr;
    } fetch_t;

    fetch_t          s1_q;
    fetch_t          grant;
    logic            grant_v;
    logic [IDW-1:0]  ptr_q;
    logic [IDW-1:0]  ptr_nxt;
    logic [STAGES:0] vld_pipe;   // [0] = S1 valid, [1] = S2 (ack) valid
    logic            win_q;
    logic            win_fall;
    logic [NREQ-1:0] in_s1;
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] ack_q;
    logic [NREQ-1:0] s1_onehot;
    logic [DW-1:0]   data_q;

    assign win_fall  = win_q & ~window;
    assign s1_onehot = NREQ'(1) << s1_q.id;

    for (genvar i = 0; i < NREQ; i++) begin : g_s1
        assign in_s1[i] = vld_pipe[0] && (s1_q.id == IDW'(i));
    end

    sprite_rom_arbiter_lane u_lane [NREQ-1:0] (
        .clk         (clk),
        .reset       (reset),
        .req         (bus.req),
        .in_s1       (in_s1),
        .acked       (ack_q),
        .win_fall    (win_fall),
        .frame_start (frame_start),
        .eligible    (eligible),
        .miss        (miss)
    );

    // Scan from ptr upward with wrap; the extra index bit keeps the wrap exact
    // for non-power-of-two NREQ.
    always_comb begin
        logic [IDW:0]   jw;
        logic [IDW-1:0] j;
        grant_v = 1'b0;
        grant   = '0;
        jw      = '0;
        j       = '0;
        for (int k = 0; k < NREQ; k++) begin
            jw = {1'b0, ptr_q} + (IDW+1)'(k);
            if (jw >= (IDW+1)'(NREQ)) jw = jw - (IDW+1)'(NREQ);
            j = jw[IDW-1:0];
            if (!grant_v && window && eligible[j]) begin
                grant_v    = 1'b1;
                grant.id   = j;
                grant.addr = bus.addr[j];
            end
        end
    end

    assign ptr_nxt = (grant.id == IDW'(NREQ-1)) ? '0 : grant.id + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q     <= '0;
            ptr_q    <= '0;
            vld_pipe <= '0;
            ack_q    <= '0;
            data_q   <= '0;
            win_q    <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], grant_v};
            win_q    <= window;
            data_q   <= bus.rom_bits;
            ack_q    <= vld_pipe[0] ? s1_onehot : '0;
            if (grant_v) begin
                s1_q  <= grant;
                ptr_q <= ptr_nxt;
            end
        end
    end

    assign bus.rom_addr = s1_q.addr;
    assign bus.ack      = ack_q;
    assign bus.data     = data_q;
    assign busy         = vld_pipe[0] | vld_pipe[1];
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: stimulus pushes expected acks into a queue,
// a negedge monitor pops and compares every ack the DUT presents.
module tb_sprite_rom_arbiter;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       window = 1'b0;
    logic       frame_start = 1'b0;
    logic       busy;
    logic [3:0] miss;

    int checks = 0;
    int failures = 0;
    int rows_left [4];

    typedef struct {
        logic [3:0] ack;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];

    sprite_rom_arbiter_if #(.NREQ(4), .AW(4), .DW(8)) bus ();

    sprite_rom_arbiter #(.NREQ(4), .AW(4), .DW(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .window      (window),
        .frame_start (frame_start),
        .bus         (bus),
        .busy        (busy),
        .miss        (miss)
    );

    // ROM contents: ROM[a] = 8'hA0 + a
    assign bus.rom_bits = 8'hA0 + {4'h0, bus.rom_addr};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout want=finish");
        $fatal(1);
    end

    always @(negedge clk) begin
        if (reset && bus.ack != 4'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_ack got ack=%b data=%h want no ack", bus.ack, bus.data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus.ack !== e.ack || bus.data !== e.data) begin
                    failures++;
                    $display("FAIL ack_data got ack=%b data=%h want ack=%b data=%h",
                             bus.ack, bus.data, e.ack, e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic expect_ack(input logic [3:0] a, input logic [7:0] d);
        exp_t e;
        e.ack  = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // One clock; renderers that saw their ack take the next row or drop req.
    task automatic tick();
        logic [3:0] a;
        a = bus.ack;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (a[i]) begin
                if (rows_left[i] > 1) begin
                    rows_left[i]--;
                    bus.addr[i] = bus.addr[i] + 4'd1;
                end else begin
                    rows_left[i] = 0;
                    bus.req[i]   = 1'b0;
                end
            end
        end
    endtask

    task automatic drain(input int limit);
        for (int n = 0; n < limit && exp_q.size() > 0; n++) tick();
        check("drain_left", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        bus.req     = '0;
        bus.addr    = '0;
        window      = 1'b0;
        frame_start = 1'b0;
        for (int i = 0; i < 4; i++) rows_left[i] = 0;
        reset = 1'b0;
        #1;
        check("rst_rom_addr", bus.rom_addr, 0);
        check("rst_ack", bus.ack, 0);
        check("rst_data", bus.data, 0);
        check("rst_busy", busy, 0);
        check("rst_miss", miss, 0);
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        bus.req  = '0;
        bus.addr = '0;

        // 1: single request
        do_reset();
        window = 1'b1;
        bus.addr[0] = 4'd5; rows_left[0] = 1; bus.req = 4'b0001;
        expect_ack(4'b0001, 8'hA5);
        tick();
        check("t1_rom_addr", bus.rom_addr, 5);
        check("t1_busy_s1", busy, 1);
        check("t1_no_early_ack", bus.ack, 0);
        tick();
        check("t1_busy_s2", busy, 1);
        tick(); tick(); tick();
        check("t1_idle", busy, 0);
        check("t1_req_dropped", bus.req, 0);

        // 2: all four at once, drained in order 0..3 back to back
        do_reset();
        window = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.addr[i]  = 4'(i + 1);
            rows_left[i] = 1;
        end
        bus.req = 4'b1111;
        expect_ack(4'b0001, 8'hA1);
        expect_ack(4'b0010, 8'hA2);
        expect_ack(4'b0100, 8'hA3);
        expect_ack(4'b1000, 8'hA4);
        for (int e = 1; e <= 5; e++) begin
            tick();
            check($sformatf("t2_busy_e%0d", e), busy, 1);
        end
        tick();
        check("t2_idle", busy, 0);
        check("t2_queue", exp_q.size(), 0);

        // 3: fairness, renderers 0 and 2 each fetch three successive rows
        do_reset();
        window = 1'b1;
        bus.addr[0] = 4'd7; rows_left[0] = 3;
        bus.addr[2] = 4'd9; rows_left[2] = 3;
        bus.req = 4'b0101;
        expect_ack(4'b0001, 8'hA7);
        expect_ack(4'b0100, 8'hA9);
        expect_ack(4'b0001, 8'hA8);
        expect_ack(4'b0100, 8'hAA);
        expect_ack(4'b0001, 8'hA9);
        expect_ack(4'b0100, 8'hAB);
        drain(20);
        tick(); tick();
        check("t3_req_done", bus.req, 0);

        // 4: window closes with renderer 3 still waiting
        do_reset();
        window = 1'b1;
        bus.addr[1] = 4'd2; rows_left[1] = 1;
        bus.addr[3] = 4'd6; rows_left[3] = 1;
        bus.req = 4'b1010;
        expect_ack(4'b0010, 8'hA2);
        tick();
        window = 1'b0;
        tick();
        check("t4_miss_set", miss, 4'b1000);
        tick();
        check("t4_miss_sticky", miss, 4'b1000);
        check("t4_queue", exp_q.size(), 0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("t4_miss_clear", miss, 4'b0000);

        // 5: reset between S1 and S2 discards the fetch; ptr restarts at 0
        do_reset();
        window = 1'b1;
        bus.addr[1] = 4'd3; rows_left[1] = 1;
        bus.addr[2] = 4'd4; rows_left[2] = 1;
        bus.req = 4'b0110;
        tick();
        check("t5_rom_addr_pre", bus.rom_addr, 3);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t5_rst_ack", bus.ack, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_rom_addr", bus.rom_addr, 0);
        check("t5_rst_data", bus.data, 0);
        tick();
        tick();
        reset = 1'b1;
        expect_ack(4'b0010, 8'hA3);
        expect_ack(4'b0100, 8'hA4);
        drain(10);

        // 6: window close and frame_start on the same cycle, set wins
        do_reset();
        window = 1'b1;
        tick();
        bus.req = 4'b0100; bus.addr[2] = 4'd1; rows_left[2] = 1;
        window = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("t6_miss_set_wins", miss, 4'b0100);
        tick();
        check("t6_miss_hold", miss, 4'b0100);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("t6_miss_clear", miss, 4'b0000);

        tick(); tick();
        check("final_queue", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
